// File: rtl/wf68k30l_reglist_sequencer.sv
// Register-list sequencer: walks a register mask, one pointer per bus transfer, with EA offset and FIRST/LAST flags.
// Optional addressing-register write inhibit is enabled by defining WF68K30L_RLSEQ_INHWR_EN.
module wf68k30l_reglist_sequencer #(
  parameter int NREGS = 16,
  parameter int ADR_W = 6,
  parameter int PW    = $clog2(NREGS)
) (
  input  logic             CLK,
  input  logic             RESET_CPU,
  input  logic             START,
  input  logic [NREGS-1:0] MASK,
  input  logic [1:0]       MODE,
  input  logic             SIZE_LONG,
  input  logic [PW-1:0]    BASE_REG,
  input  logic             XFER_ACK,
  input  logic             ABORT,
  output logic             BUSY,
  output logic             XFER_REQ,
  output logic [PW-1:0]    PNTR,
  output logic             ADn,
  output logic [ADR_W-1:0] OFFSET,
  output logic             FIRST,
  output logic             LAST,
  output logic             DONE,
  output logic             INH_WR
);

  typedef enum logic [1:0] {S_IDLE, S_XFER, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [NREGS-1:0]   pend_q, pend_d;
  logic [1:0]         mode_q, mode_d;
  logic               long_q, long_d;
  logic [ADR_W-1:0]   offset_q, offset_d;
  logic               first_q, first_d;
  logic [PW-1:0]      pntr_q, pntr_d;
  logic               inh_q, inh_d;
  logic               busy_q, xfer_q, done_q;
  logic [NREGS-1:0]   low_bit, pend_rest;
  logic [1:0]         start_mode;

  function automatic logic [PW-1:0] lowest(input logic [NREGS-1:0] v);
    lowest = '0;
    for (int i = NREGS - 1; i >= 0; i--) begin
      if (v[i]) lowest = PW'(i);
    end
  endfunction

  // Predecrement lists are stored reversed, so NREGS-1-i is simply the bitwise inverse of i.
  function automatic logic [PW-1:0] to_pntr(input logic [PW-1:0] idx, input logic [1:0] m);
    to_pntr = (m == 2'b10) ? ~idx : idx;
  endfunction

  assign low_bit    = pend_q & (~pend_q + NREGS'(1));
  assign pend_rest  = pend_q & ~low_bit;
  assign start_mode = (MODE == 2'b11) ? 2'b00 : MODE;

  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q;
    mode_d   = mode_q;
    long_d   = long_q;
    offset_d = offset_q;
    first_d  = first_q;
    pntr_d   = pntr_q;
    case (state_q)
      S_IDLE: begin
        if (START) begin
          if (MASK != '0) begin
            pend_d   = MASK;
            mode_d   = start_mode;
            long_d   = SIZE_LONG;
            offset_d = '0;
            first_d  = 1'b1;
            pntr_d   = to_pntr(lowest(MASK), start_mode);
            state_d  = S_XFER;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_XFER: begin
        if (XFER_ACK) begin
          first_d = 1'b0;
          pend_d  = pend_rest;
          if (LAST) begin
            state_d  = S_DONE;
            pntr_d   = '0;
            offset_d = '0;
          end else begin
            pntr_d = to_pntr(lowest(pend_rest), mode_q);
            // Auto-increment/decrement modes take the address from An itself.
            if (mode_q == 2'b00) offset_d = offset_q + (long_q ? ADR_W'(4) : ADR_W'(2));
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (ABORT) begin
      state_d  = S_IDLE;
      pend_d   = '0;
      offset_d = '0;
      first_d  = 1'b0;
      pntr_d   = '0;
    end
  end

`ifdef WF68K30L_RLSEQ_INHWR_EN
  assign inh_d = (state_d == S_XFER) && (mode_d == 2'b01) &&
                 (pntr_d == {1'b1, BASE_REG[PW-2:0]});
`else
  logic unused_base_reg;
  assign unused_base_reg = ^BASE_REG;
  assign inh_d = 1'b0;
`endif

  always_ff @(posedge CLK or posedge RESET_CPU) begin
    if (RESET_CPU) begin
      state_q  <= S_IDLE;
      pend_q   <= '0;
      mode_q   <= 2'b00;
      long_q   <= 1'b0;
      offset_q <= '0;
      first_q  <= 1'b0;
      pntr_q   <= '0;
      inh_q    <= 1'b0;
      busy_q   <= 1'b0;
      xfer_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      mode_q   <= mode_d;
      long_q   <= long_d;
      offset_q <= offset_d;
      first_q  <= first_d;
      pntr_q   <= pntr_d;
      inh_q    <= inh_d;
      busy_q   <= (state_d != S_IDLE);
      xfer_q   <= (state_d == S_XFER);
      done_q   <= (state_d == S_DONE);
    end
  end

  assign BUSY     = busy_q;
  assign XFER_REQ = xfer_q;
  assign PNTR     = pntr_q;
  assign ADn      = pntr_q[PW-1];
  assign OFFSET   = offset_q;
  assign FIRST    = first_q;
  assign LAST     = (state_q == S_XFER) && ((pend_q & (pend_q - NREGS'(1))) == '0);
  assign DONE     = done_q;
  assign INH_WR   = inh_q;

endmodule

// File: tb/tb_wf68k30l_reglist_sequencer.sv
// Scoreboard bench for wf68k30l_reglist_sequencer: a list model fills an expectation array, a negedge monitor checks it.
module tb_wf68k30l_reglist_sequencer;
  localparam int NREGS = 16;
  localparam int PW    = 4;
  localparam int ADR_W = 6;
`ifdef WF68K30L_RLSEQ_INHWR_EN
  localparam bit INHW = 1'b1;
`else
  localparam bit INHW = 1'b0;
`endif

  logic             CLK = 1'b0;
  logic             RESET_CPU = 1'b1;
  logic             START = 1'b0;
  logic [NREGS-1:0] MASK = '0;
  logic [1:0]       MODE = 2'b00;
  logic             SIZE_LONG = 1'b0;
  logic [PW-1:0]    BASE_REG = '0;
  logic             XFER_ACK = 1'b0;
  logic             ABORT = 1'b0;
  logic             BUSY, XFER_REQ, ADn, FIRST, LAST, DONE, INH_WR;
  logic [PW-1:0]    PNTR;
  logic [ADR_W-1:0] OFFSET;

  always #5 CLK = ~CLK;

  wf68k30l_reglist_sequencer dut (
    .CLK(CLK), .RESET_CPU(RESET_CPU), .START(START), .MASK(MASK), .MODE(MODE),
    .SIZE_LONG(SIZE_LONG), .BASE_REG(BASE_REG), .XFER_ACK(XFER_ACK), .ABORT(ABORT),
    .BUSY(BUSY), .XFER_REQ(XFER_REQ), .PNTR(PNTR), .ADn(ADn), .OFFSET(OFFSET),
    .FIRST(FIRST), .LAST(LAST), .DONE(DONE), .INH_WR(INH_WR)
  );

  typedef struct packed {
    logic             is_done;
    logic [PW-1:0]    p;
    logic             adn;
    logic [ADR_W-1:0] off;
    logic             first;
    logic             last;
    logic             inh;
  } exp_t;

  // Expectation FIFO: written only by the stimulus process, read only by the monitor.
  exp_t sb [0:2047];
  int   wr_ptr = 0;
  int   rd_ptr = 0;
  int   checks = 0;
  int   errors = 0;
  int   dir_tag = 0;
  int   dir_kind = 0;
  int   dir_seen = 0;
  bit   mon_en = 1'b0;

  task automatic push(input exp_t e);
    sb[wr_ptr % 2048] = e;
    wr_ptr++;
  endtask

  // Directed checks are requested by the stimulus and evaluated at the next monitor sample.
  task automatic post(input int k);
    dir_kind = k;
    dir_tag++;
  endtask

  always @(negedge CLK) begin
    if (mon_en) begin
      if (dir_tag != dir_seen) begin
        dir_seen = dir_tag;
        checks++;
        case (dir_kind)
          1: if (!(XFER_REQ && BUSY && FIRST && !DONE)) begin
               errors++;
               $display("FAIL start_latency: XFER_REQ=%0b BUSY=%0b FIRST=%0b DONE=%0b required 1 1 1 0",
                        XFER_REQ, BUSY, FIRST, DONE);
             end
          2: if (!(!XFER_REQ && BUSY && DONE)) begin
               errors++;
               $display("FAIL empty_mask: XFER_REQ=%0b BUSY=%0b DONE=%0b required 0 1 1", XFER_REQ, BUSY, DONE);
             end
          3: if ({BUSY, XFER_REQ, PNTR, ADn, OFFSET, FIRST, LAST, DONE, INH_WR} != '0) begin
               errors++;
               $display("FAIL idle_zero: BUSY=%0b REQ=%0b PNTR=%0d ADn=%0b OFF=%0d FIRST=%0b LAST=%0b DONE=%0b INH=%0b required all 0",
                        BUSY, XFER_REQ, PNTR, ADn, OFFSET, FIRST, LAST, DONE, INH_WR);
             end
          4: if (rd_ptr != wr_ptr || BUSY) begin
               errors++;
               $display("FAIL drained: pending=%0d BUSY=%0b required 0 0", wr_ptr - rd_ptr, BUSY);
             end
          default: begin
               errors++;
               $display("FAIL timeout: sequence did not complete within its cycle budget");
             end
        endcase
      end
      if (DONE) begin
        checks++;
        if (rd_ptr == wr_ptr || !sb[rd_ptr % 2048].is_done || XFER_REQ || !BUSY) begin
          errors++;
          $display("FAIL done_pulse: DONE=1 REQ=%0b BUSY=%0b pending=%0d required end-of-list DONE with REQ=0 BUSY=1",
                   XFER_REQ, BUSY, wr_ptr - rd_ptr);
        end else begin
          $display("done  pulse ok");
          rd_ptr++;
        end
      end
      if (XFER_REQ) begin
        checks++;
        if (rd_ptr == wr_ptr || sb[rd_ptr % 2048].is_done) begin
          errors++;
          $display("FAIL unexpected_xfer: PNTR=%0d OFF=%0d required no transfer", PNTR, OFFSET);
        end else if ({PNTR, ADn, OFFSET, FIRST, LAST, INH_WR} != {sb[rd_ptr % 2048].p, sb[rd_ptr % 2048].adn,
                     sb[rd_ptr % 2048].off, sb[rd_ptr % 2048].first, sb[rd_ptr % 2048].last, sb[rd_ptr % 2048].inh}) begin
          errors++;
          $display("FAIL xfer: PNTR=%0d ADn=%0b OFF=%0d FIRST=%0b LAST=%0b INH=%0b required %0d %0b %0d %0b %0b %0b",
                   PNTR, ADn, OFFSET, FIRST, LAST, INH_WR, sb[rd_ptr % 2048].p, sb[rd_ptr % 2048].adn,
                   sb[rd_ptr % 2048].off, sb[rd_ptr % 2048].first, sb[rd_ptr % 2048].last, sb[rd_ptr % 2048].inh);
          if (XFER_ACK) rd_ptr++;
        end else if (XFER_ACK) begin
          $display("xfer  PNTR=%0d OFF=%0d FIRST=%0b LAST=%0b INH=%0b ABORT=%0b", PNTR, OFFSET, FIRST, LAST, INH_WR, ABORT);
          rd_ptr++;
        end
      end
    end
  end

  // Reference list: every set mask bit, lowest first, mapped to its register and byte offset.
  task automatic build_expect(input logic [NREGS-1:0] m, input logic [1:0] md, input bit lng,
                              input logic [PW-1:0] base, input int abort_at);
    int   n;
    int   total;
    int   reg_no;
    exp_t e;
    n = 0;
    total = $countones(m);
    for (int i = 0; i < NREGS; i++) begin
      if (m[i]) begin
        reg_no  = (md == 2'd2) ? (NREGS - 1 - i) : i;
        e       = '0;
        e.p     = PW'(reg_no);
        e.adn   = (reg_no >= NREGS / 2);
        e.off   = (md == 2'd0 || md == 2'd3) ? ADR_W'((n * (lng ? 4 : 2)) % (1 << ADR_W)) : '0;
        e.first = (n == 0);
        e.last  = (n == total - 1);
        e.inh   = INHW && (md == 2'd1) && (reg_no == NREGS / 2 + (int'(base) % (NREGS / 2)));
        if (abort_at < 0 || n <= abort_at) push(e);
        n++;
      end
    end
    if (abort_at < 0) begin
      e = '0;
      e.is_done = 1'b1;
      push(e);
    end
  endtask

  // ack_mode: 0 random, 1 every cycle, 2 held low for the first three cycles.
  task automatic run_seq(input logic [NREGS-1:0] m, input logic [1:0] md, input bit lng,
                         input logic [PW-1:0] base, input int abort_at, input int ack_mode);
    int n;
    int acked;
    int cyc;
    bit aborted;
    bit ack;
    n = $countones(m);
    build_expect(m, md, lng, base, abort_at);
    @(posedge CLK); #1;
    START = 1'b1; MASK = m; MODE = md; SIZE_LONG = lng; BASE_REG = base;
    @(posedge CLK); #1;
    START = 1'b0; MASK = NREGS'($urandom); MODE = 2'($urandom); SIZE_LONG = 1'($urandom);
    if (n == 0) begin
      post(2);
      START = 1'b1; MASK = '1;
      @(posedge CLK); #1;
      START = 1'b0;
      post(4);
      @(posedge CLK); #1;
      return;
    end
    post(1);
    acked = 0; cyc = 0; aborted = 1'b0;
    while (acked < n && !aborted) begin
      case (ack_mode)
        1:       ack = 1'b1;
        2:       ack = (cyc >= 3);
        default: ack = ($urandom_range(3) != 0);
      endcase
      XFER_ACK = ack;
      ABORT    = ack && (acked == abort_at);
      START    = ($urandom_range(2) == 0);
      MASK     = NREGS'($urandom);
      @(posedge CLK); #1;
      if (ABORT) aborted = 1'b1;
      else if (ack) acked++;
      XFER_ACK = 1'b0; ABORT = 1'b0; START = 1'b0;
      cyc++;
      if (cyc > 400) begin
        post(5);
        @(posedge CLK); #1;
        return;
      end
    end
    if (aborted) begin
      post(3);
      @(posedge CLK); #1;
      post(4);
    end else begin
      START = 1'b1; MASK = '1;
      @(posedge CLK); #1;
      START = 1'b0;
      post(4);
    end
    @(posedge CLK); #1;
  endtask

  initial begin
    logic [NREGS-1:0] rm;
    int               ab;
    repeat (2) @(posedge CLK);
    #1;
    mon_en = 1'b1;
    post(3);
    @(posedge CLK); #1;
    RESET_CPU = 1'b0;
    @(posedge CLK); #1;
    run_seq(16'h0000, 2'd0, 1'b0, 4'd0, -1, 1);
    run_seq(16'h8101, 2'd0, 1'b1, 4'd0, -1, 1);
    run_seq(16'h0003, 2'd2, 1'b0, 4'd0, -1, 1);
    run_seq(16'h0006, 2'd0, 1'b0, 4'd0, -1, 2);
    run_seq(16'hFFFF, 2'd0, 1'b1, 4'd0, 1, 1);
    run_seq(16'hFFFF, 2'd0, 1'b1, 4'd0, -1, 1);
    run_seq(16'h0300, 2'd1, 1'b0, 4'd1, -1, 1);
    run_seq(16'hFFFF, 2'd3, 1'b0, 4'd0, -1, 0);
    for (int t = 0; t < 40; t++) begin
      rm = ($urandom_range(5) == 0) ? '0 : NREGS'($urandom);
      ab = (rm != '0 && $urandom_range(3) == 0) ? int'($urandom_range($countones(rm) - 1)) : -1;
      run_seq(rm, 2'($urandom), 1'($urandom), PW'($urandom), ab, 0);
    end
    @(posedge CLK); #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end
endmodule
